// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state and
// transaction owner encodings, plus a counter-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// Priority decision between fetch and data requesters, with the streak
// counter that forces a fetch grant after STARVE_LIMIT back-to-back data wins.
module arb_grant #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_if,
  output logic grant_d
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          starve;

  assign starve = (streak_q == SW'(STARVE_LIMIT));

  always_comb begin
    grant_if = grant_en & if_req & (~d_req | starve);
    grant_d  = grant_en & d_req & ~grant_if;
    streak_d = streak_q;
    if (grant_if) begin
      streak_d = '0;
    end else if (grant_d) begin
      // Only a data win that actually kept fetch waiting counts toward starvation.
      if (!if_req)      streak_d = '0;
      else if (!starve) streak_d = streak_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs and updates together at the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak_q <= '0;
    else      streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port registered-output memory between instruction fetch
// and MEM-stage data access; one transaction in flight, data has priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam int unsigned CW = cnt_width(MEM_LATENCY);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_en, grant_if, grant_d;

  assign grant_en = (state_q == ARB_IDLE);

  arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant_en (grant_en),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // NOTE: every signal gets its hold value first, so no branch of the case
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_if || grant_d) begin
          owner_d = grant_d ? OWNER_D : OWNER_IF;
          we_d    = grant_d & d_we;
          addr_d  = grant_d ? d_addr : if_addr;
          if (grant_d) wdata_d = d_wdata;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = CW'(MEM_LATENCY - 1);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWNER_IF) if_rdata_d = mem_q;
          else if (!we_q)          d_rdata_d  = mem_q;
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Address/data come straight from the grant latch, so they hold between issues.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rden  = (state_q == ARB_ISSUE) & ~we_q;
  assign mem_wren  = (state_q == ARB_ISSUE) &  we_q;
  assign busy      = (state_q != ARB_IDLE);
  assign if_ack    = (state_q == ARB_DONE) & (owner_q == OWNER_IF);
  assign d_ack     = (state_q == ARB_DONE) & (owner_q == OWNER_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a transaction-level model
// predicts every output each cycle; a second instance covers MEM_LATENCY=3.
module tb_mem_arbiter;

  localparam int AW = 10, DW = 32, LAT = 1, SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance (MEM_LATENCY=1)
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_ack, d_ack, mem_wren, mem_rden, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_q = '0;
  logic [AW-1:0] mem_addr;

  // second instance (MEM_LATENCY=3)
  logic          if_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
  logic [AW-1:0] if_addr3 = '0, d_addr3 = '0;
  logic [DW-1:0] d_wdata3 = '0;
  logic          if_ack3, d_ack3, mem_wren3, mem_rden3, busy3;
  logic [DW-1:0] if_rdata3, d_rdata3, mem_wdata3, mem_q3;
  logic [AW-1:0] mem_addr3;

  int n_total = 0;
  int n_bad   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rden(mem_rden), .mem_q(mem_q), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .STARVE_LIMIT(SL)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wren(mem_wren3),
    .mem_rden(mem_rden3), .mem_q(mem_q3), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-on memory contents; a few words are pinned to recognisable values.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    case (a)
      10'h010: return 32'hDEAD_BEEF;
      10'h030: return 32'hCAFE_F00D;
      10'h055: return 32'h0BAD_C0DE;
      default: return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory behind the main instance: registered q one cycle after the strobe.
  bit [DW-1:0] ram1 [1024];
  bit          vld1 [1024];
  always @(posedge clk) begin
    if (mem_wren) begin
      ram1[mem_addr] <= mem_wdata;
      vld1[mem_addr] <= 1'b1;
    end
    mem_q <= mem_rden ? (vld1[mem_addr] ? ram1[mem_addr] : init_word(mem_addr)) : $urandom;
  end

  // Memory behind the latency-3 instance: read-only, three-stage q pipeline.
  bit [DW-1:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= mem_rden3 ? init_word(mem_addr3) : $urandom;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_q3 = p3[2];

  // Reference model: a transaction is granted in an idle cycle, then spends
  // 1 issue cycle, LAT wait cycles and 1 ack cycle (phase 1..LAT+2).
  int            m_phase = 0, m_streak = 0;
  logic          m_own_d = 1'b0, m_store = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_result = '0, m_if_rd = '0, m_d_rd = '0;
  bit   [DW-1:0] m_mem [1024];
  bit            m_vld [1024];
  wire           pick_d = d_req && !(if_req && m_streak == SL);
  wire [AW-1:0]  pick_addr = pick_d ? d_addr : if_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_streak <= 0; m_own_d <= 1'b0; m_store <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_if_rd <= '0; m_d_rd <= '0;
    end else if (m_phase == 0) begin
      if (if_req || d_req) begin
        m_phase  <= 1;
        m_own_d  <= pick_d;
        m_store  <= pick_d && d_we;
        m_addr   <= pick_addr;
        m_wdata  <= d_wdata;
        m_streak <= (pick_d && if_req) ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
        if (pick_d && d_we) begin
          m_mem[d_addr] <= d_wdata;
          m_vld[d_addr] <= 1'b1;
        end else begin
          m_result <= m_vld[pick_addr] ? m_mem[pick_addr] : init_word(pick_addr);
        end
      end
    end else if (m_phase == LAT + 2) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == LAT + 1 && !m_store) begin
        if (m_own_d) m_d_rd  <= m_result;
        else         m_if_rd <= m_result;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",     32'(busy),     32'(m_phase != 0));
    check("mem_rden", 32'(mem_rden), 32'(m_phase == 1 && !m_store));
    check("mem_wren", 32'(mem_wren), 32'(m_phase == 1 && m_store));
    check("if_ack",   32'(if_ack),   32'(m_phase == LAT + 2 && !m_own_d));
    check("d_ack",    32'(d_ack),    32'(m_phase == LAT + 2 && m_own_d));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("if_rdata", if_rdata, m_if_rd);
    check("d_rdata",  d_rdata,  m_d_rd);
    if (m_phase == 1 && m_store) check("mem_wdata", mem_wdata, m_wdata);
  end

  // Counts negedges from the request cycle until the wanted ack; cyc=4 means ack in cycle 3.
  task automatic wait_ack(input string name, input bit want_d, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = want_d ? d_ack : if_ack;
    end
    check({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, wren_cnt, d_run, i_cnt, n_ack;
    bit got, ia, da;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_rdata",    d_rdata | if_rdata, 32'd0);
    check("rst_strobes",  32'({mem_rden, mem_wren, if_ack, d_ack}), 32'd0);
    @(negedge clk) rst = 1'b1;

    // single load: strobe in cycle 1, ack with data in cycle 3
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
    repeat (2) @(negedge clk);
    check("t1_rden", 32'(mem_rden), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h010);
    @(negedge clk);
    check("t1_early_ack", 32'(d_ack), 32'd0);
    @(negedge clk);
    check("t1_d_ack",  32'(d_ack),  32'd1);
    check("t1_if_ack", 32'(if_ack), 32'd0);
    check("t1_rdata",  d_rdata, 32'hDEAD_BEEF);
    check("t1_model_pin", m_d_rd, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    d_req = 1'b0;

    // store then fetch the same word
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'h1234_5678;
    wren_cnt = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_wren) wren_cnt++;
      got = d_ack;
    end
    check("t2_store_ack", 32'(got), 32'd1);
    check("t2_wren_once", 32'(wren_cnt), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 10'h020;
    wait_ack("t2_fetch", 1'b0, cyc);
    check("t2_fetch_lat", 32'(cyc), 32'd4);
    check("t2_if_rdata",  if_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    if_req = 1'b0;

    // both requesters held: DDDD I DDDD I
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 10'h003; d_req = 1'b1; d_addr = 10'h004;
    d_run = 0; i_cnt = 0; n_ack = 0;
    for (int k = 0; k < 150 && n_ack < 10; k++) begin
      @(negedge clk);
      if (d_ack) begin d_run++; n_ack++; end
      if (if_ack) begin
        check("t3_d_run", 32'(d_run), 32'd4);
        d_run = 0; i_cnt++; n_ack++;
      end
    end
    check("t3_if_acks", 32'(i_cnt), 32'd2);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;

    // idle for 10 cycles
    repeat (10) begin
      @(negedge clk);
      check("t6_idle", 32'({busy, mem_rden, mem_wren}), 32'd0);
    end

    // reset during WAIT
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("t4_busy",  32'(busy), 32'd0);
    check("t4_strb",  32'({mem_rden, mem_wren, if_ack, d_ack}), 32'd0);
    check("t4_rdata", d_rdata | if_rdata, 32'd0);
    check("t4_addr",  32'(mem_addr), 32'd0);
    d_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_no_ack", 32'({if_ack, d_ack}), 32'd0);
    end
    @(posedge clk); #1;
    d_req = 1'b1;
    wait_ack("t4_reissue", 1'b1, cyc);
    check("t4_lat",   32'(cyc), 32'd4);
    check("t4_rdata2", d_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    d_req = 1'b0;

    // MEM_LATENCY=3 instance: ack in cycle 5, late address change ignored
    @(posedge clk); #1;
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 10'h055;
    repeat (2) @(negedge clk);
    check("t5_rden", 32'(mem_rden3), 32'd1);
    check("t5_addr", 32'(mem_addr3), 32'h055);
    @(posedge clk); #1;
    d_addr3 = 10'h0AA;
    repeat (3) begin
      @(negedge clk);
      check("t5_no_ack",  32'(d_ack3), 32'd0);
      check("t5_hold_addr", 32'(mem_addr3), 32'h055);
    end
    @(negedge clk);
    check("t5_ack",   32'(d_ack3), 32'd1);
    check("t5_rdata", d_rdata3, 32'h0BAD_C0DE);
    @(posedge clk); #1;
    d_req3 = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      ia = if_ack; da = d_ack;
      @(posedge clk); #1;
      if (ia)           if_req = 1'($urandom_range(0, 1));
      else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      if (da)           d_req = 1'($urandom_range(0, 1));
      else if (!d_req)  d_req = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) if_addr = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        d_addr  = AW'($urandom_range(0, 31));
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
